// File: rtl/ept_req_arb.sv
// Round-robin arbiter sharing one gpa->hpa XOR translation between NUM_REQ
// requesters, with a writable per-VM key/enable table and one registered response slot.

module ept_req_lane #(
  parameter int ID_W = 2,
  parameter int IDX  = 0
) (
  input  logic [ID_W-1:0] ptr,
  input  logic            valid,
  output logic            hi
);
  // Requester sits at or above the round-robin pointer: first search pass.
  assign hi = valid && (IDX >= int'(ptr));
endmodule

module ept_req_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*8-1:0]    req_vmid_i,
  input  logic [NUM_REQ*64-1:0]   req_gpa_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [63:0]             rsp_hpa_o,
  output logic                    rsp_fault_o,
  input  logic                    cfg_we_i,
  input  logic [7:0]              cfg_vmid_i,
  input  logic [63:0]             cfg_key_i,
  input  logic                    cfg_en_i,
  output logic                    busy_o
);
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            fault;
    logic [63:0]     hpa;
  } rsp_t;

  logic [255:0][63:0]          key_q;
  logic [255:0]                en_q;
  logic [ID_W-1:0]             ptr_q;
  logic                        run_q;
  logic                        rsp_vld_q;
  rsp_t                        rsp_q;

  logic [NUM_REQ-1:0][7:0]     vmid_a;
  logic [NUM_REQ-1:0][63:0]    gpa_a;
  logic [NUM_REQ-1:0]          hi;
  logic [NUM_REQ-1:0]          gnt_oh;
  logic [ID_W-1:0]             gnt_id;
  logic [ID_W-1:0]             ptr_nxt;
  logic                        gnt_vld;
  logic                        slot_free;
  logic                        xfer;
  logic [7:0]                  sel_vmid;
  logic [63:0]                 sel_gpa;

  assign vmid_a = req_vmid_i;
  assign gpa_a  = req_gpa_i;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    ept_req_lane #(.ID_W(ID_W), .IDX(g)) u_lane (
      .ptr   (ptr_q),
      .valid (req_valid_i[g]),
      .hi    (hi[g])
    );
  end

  assign slot_free = !rsp_vld_q || rsp_ready_i;

  // Lowest valid at/after the pointer wins; otherwise wrap to the lowest valid.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    gnt_oh  = '0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (req_valid_i[i]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(i);
      end
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (hi[i]) gnt_id = ID_W'(i);
    for (int i = 0; i < NUM_REQ; i++)
      gnt_oh[i] = slot_free && run_q && gnt_vld && (gnt_id == ID_W'(i));
  end

  assign xfer        = |gnt_oh;
  assign req_ready_o = gnt_oh;
  assign ptr_nxt     = (int'(gnt_id) == NUM_REQ-1) ? '0 : gnt_id + 1'b1;
  assign sel_vmid    = vmid_a[gnt_id];
  assign sel_gpa     = gpa_a[gnt_id];

  // Table reads use pre-edge contents, so a same-cycle config write is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q     <= '0;
      en_q      <= '0;
      ptr_q     <= '0;
      run_q     <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      run_q <= 1'b1;
      if (xfer) begin
        rsp_vld_q   <= 1'b1;
        rsp_q.id    <= gnt_id;
        rsp_q.fault <= !en_q[sel_vmid];
        rsp_q.hpa   <= en_q[sel_vmid] ? (sel_gpa ^ key_q[sel_vmid]) : 64'd0;
        ptr_q       <= ptr_nxt;
      end else if (rsp_ready_i) begin
        rsp_vld_q <= 1'b0;
      end
      if (cfg_we_i) begin
        key_q[cfg_vmid_i] <= cfg_key_i;
        en_q[cfg_vmid_i]  <= cfg_en_i;
      end
    end
  end

  assign rsp_valid_o = rsp_vld_q;
  assign rsp_id_o    = rsp_q.id;
  assign rsp_hpa_o   = rsp_q.hpa;
  assign rsp_fault_o = rsp_q.fault;
  assign busy_o      = rsp_vld_q || (|req_valid_i);
endmodule

// File: tb/tb_ept_req_arb.sv
// Directed bench for ept_req_arb: reset, translate, fault, round-robin,
// backpressure, config read-before-write and mid-operation reset.

module tb_ept_req_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_vmid;
  logic [255:0] req_gpa;
  logic        rsp_valid, rsp_ready, rsp_fault, busy;
  logic [1:0]  rsp_id;
  logic [63:0] rsp_hpa;
  logic        cfg_we, cfg_en;
  logic [7:0]  cfg_vmid;
  logic [63:0] cfg_key;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ept_req_arb #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_vmid_i(req_vmid), .req_gpa_i(req_gpa),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_hpa_o(rsp_hpa), .rsp_fault_o(rsp_fault),
    .cfg_we_i(cfg_we), .cfg_vmid_i(cfg_vmid), .cfg_key_i(cfg_key), .cfg_en_i(cfg_en),
    .busy_o(busy)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int r, input logic [7:0] v, input logic [63:0] g);
    req_vmid[r*8 +: 8] = v;
    req_gpa[r*64 +: 64] = g;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_vmid = '0; req_gpa = '0; rsp_ready = 1'b1;
    cfg_we = 1'b0; cfg_en = 1'b0; cfg_vmid = '0; cfg_key = '0;
    #12;
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", rsp_valid); end
    n_chk++; if (rsp_id !== 2'd0 || rsp_hpa !== 64'd0 || rsp_fault !== 1'b0) begin n_fail++; $display("FAIL reset_payload: got id %0d hpa %h fault %b exp 0", rsp_id, rsp_hpa, rsp_fault); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    req_valid = 4'b1111; #1;
    n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    step(); step();
  endtask

  task automatic test_translate();
    cfg_we = 1'b1; cfg_vmid = 8'd3; cfg_key = 64'h0000_0000_00FF_0000; cfg_en = 1'b1;
    step();
    cfg_we = 1'b0;
    req_valid = 4'b0001; set_req(0, 8'd3, 64'h1234_5678);
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL xlate_grant: got %b exp 0001", req_ready); end
    step(); req_valid = '0;
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL xlate_vld_id: got %b/%0d exp 1/0", rsp_valid, rsp_id); end
    n_chk++; if (rsp_hpa !== 64'h12CB_5678 || rsp_fault !== 1'b0) begin n_fail++; $display("FAIL xlate_hpa: got %h/%b exp 12cb5678/0", rsp_hpa, rsp_fault); end
    step();
  endtask

  task automatic test_fault();
    // pointer is 1, so requester 2 is served directly
    req_valid = 4'b0100; set_req(2, 8'd7, 64'hABCD);
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL fault_grant: got %b exp 0100", req_ready); end
    step(); req_valid = '0;
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_fault !== 1'b1 || rsp_hpa !== 64'd0) begin n_fail++; $display("FAIL fault_rsp: got v%b id%0d f%b hpa %h exp v1 id2 f1 hpa 0", rsp_valid, rsp_id, rsp_fault, rsp_hpa); end
    step();
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd2 || rsp_fault !== 1'b1) begin n_fail++; $display("FAIL drain: got v%b id%0d f%b exp v0 id2 f1", rsp_valid, rsp_id, rsp_fault); end
    step();
  endtask

  task automatic test_round_robin();
    int exp1 [5] = '{0, 1, 2, 3, 0};
    int exp2 [4] = '{2, 3, 0, 2};
    int prev;
    // pointer is 3: serve requester 3 once so the pointer returns to 0
    req_valid = 4'b1000; set_req(3, 8'd3, 64'h1003);
    step();
    for (int r = 0; r < 4; r++) set_req(r, 8'd3, 64'h1000 + 64'(r));
    req_valid = 4'b1111;
    prev = 3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++; if (req_ready !== 4'(1 << exp1[c])) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b exp %0d", c, req_ready, exp1[c]); end
      n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(prev) || rsp_hpa !== (64'hFF1000 + 64'(prev))) begin n_fail++; $display("FAIL rr_rsp[%0d]: got v%b id%0d hpa %h exp id%0d", c, rsp_valid, rsp_id, rsp_hpa, prev); end
      prev = exp1[c];
      step();
    end
    req_valid = 4'b1101;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++; if (req_ready !== 4'(1 << exp2[c])) begin n_fail++; $display("FAIL rr2_grant[%0d]: got %b exp %0d", c, req_ready, exp2[c]); end
      n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(prev)) begin n_fail++; $display("FAIL rr2_rsp[%0d]: got v%b id%0d exp id%0d", c, rsp_valid, rsp_id, prev); end
      prev = exp2[c];
      step();
    end
    req_valid = '0;
    @(negedge clk);
    n_chk++; if (rsp_id !== 2'd2 || rsp_hpa !== 64'hFF1002) begin n_fail++; $display("FAIL rr_last: got id%0d hpa %h exp id2 hpa ff1002", rsp_id, rsp_hpa); end
    step();
  endtask

  task automatic test_backpressure();
    // pointer is 3: requester 0 is served first
    req_valid = 4'b0001;
    step();
    rsp_ready = 1'b0; req_valid = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b exp 0000", c, req_ready); end
      n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_hpa !== 64'hFF1000 || rsp_fault !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: got v%b id%0d hpa %h exp v1 id0 hpa ff1000", c, rsp_valid, rsp_id, rsp_hpa); end
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy[%0d]: got %b exp 1", c, busy); end
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release: got %b exp 0010", req_ready); end
    step(); req_valid = '0;
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_hpa !== 64'hFF1001) begin n_fail++; $display("FAIL bp_next: got v%b id%0d hpa %h exp v1 id1 hpa ff1001", rsp_valid, rsp_id, rsp_hpa); end
    step();
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b exp 0", busy); end
    step();
  endtask

  task automatic test_cfg_rbw();
    cfg_we = 1'b1; cfg_vmid = 8'd3; cfg_key = 64'h1; cfg_en = 1'b1;
    req_valid = 4'b0100; set_req(2, 8'd3, 64'h10);
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rbw_grant: got %b exp 0100", req_ready); end
    step(); cfg_we = 1'b0;
    @(negedge clk);
    n_chk++; if (rsp_hpa !== 64'h00FF_0010 || rsp_id !== 2'd2) begin n_fail++; $display("FAIL rbw_old: got hpa %h id%0d exp 00ff0010 id2", rsp_hpa, rsp_id); end
    step(); req_valid = '0;
    @(negedge clk);
    n_chk++; if (rsp_hpa !== 64'h11 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rbw_new: got hpa %h v%b exp 11 v1", rsp_hpa, rsp_valid); end
  endtask

  task automatic test_reset_mid();
    n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %b exp 1", rsp_valid); end
    rst_n = 1'b0; #1;
    n_chk++; if (rsp_valid !== 1'b0 || rsp_hpa !== 64'd0) begin n_fail++; $display("FAIL mid_clear: got v%b hpa %h exp v0 hpa 0", rsp_valid, rsp_hpa); end
    @(negedge clk); rst_n = 1'b1;
    step(); step();
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_quiet: got %b exp 0", rsp_valid); end
    step();
    req_valid = 4'b0001; set_req(0, 8'd3, 64'h10);
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_grant: got %b exp 0001", req_ready); end
    step(); req_valid = '0;
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b1 || rsp_hpa !== 64'd0 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL mid_fault: got v%b f%b hpa %h id%0d exp v1 f1 hpa 0 id0", rsp_valid, rsp_fault, rsp_hpa, rsp_id); end
    step();
  endtask

  initial begin
    test_reset();
    test_translate();
    test_fault();
    test_round_robin();
    test_backpressure();
    test_cfg_rbw();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
